// File: rtl/axi4_fb_pkg.sv
// rtl/axi4_fb_pkg.sv - shared types, AXI constants and burst address helper for the FB line fetcher
package axi4_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ARCACHE    = 4'b0011;

  // Byte address of one burst of one line of one layer; evaluated wide, caller truncates.
  function automatic logic [63:0] fb_burst_addr(
    input logic [63:0] base,
    input logic [63:0] frame_bytes,
    input logic [63:0] line_bytes,
    input logic [63:0] burst_bytes,
    input logic [63:0] num_layers,
    input logic        sel,
    input logic [63:0] layer,
    input logic [63:0] line,
    input logic [63:0] burst
  );
    logic [63:0] alt_off;
    alt_off = sel ? (num_layers * frame_bytes) : 64'd0;
    return base + alt_off + layer * frame_bytes + line * line_bytes + burst * burst_bytes;
  endfunction

endpackage

// File: rtl/axi4_fb_addr_gen.sv
// rtl/axi4_fb_addr_gen.sv - layer/burst counters and registered AR address for the FB line fetcher
module axi4_fb_addr_gen
  import axi4_fb_pkg::*;
#(
  parameter int NUM_LAYERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_W          = 9,
  parameter int LAYER_W         = 1,
  parameter int BURST_W         = 3,
  parameter int BURSTS_PER_LINE = 5,
  parameter int LINE_BYTES      = 2560,
  parameter int FRAME_BYTES     = 1228800,
  parameter int BURST_BYTES     = 512,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE = ADDR_WIDTH'(32'h81000000)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  adv_i,
  input  logic                  sel_i,
  input  logic [LINE_W-1:0]     line_i,
  output logic [LAYER_W-1:0]    layer_o,
  output logic [BURST_W-1:0]    burst_o,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] araddr_o
);

  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(BURSTS_PER_LINE - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  logic [LAYER_W-1:0]    layer_q, layer_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;

  // Next burst position: restart on a new line, step burst then layer at each burst end
  always_comb begin
    layer_d  = layer_q;
    burst_d  = burst_q;
    araddr_d = araddr_q;
    if (start_i) begin
      layer_d = '0;
      burst_d = '0;
    end else if (adv_i) begin
      if (burst_q == LAST_BURST) begin
        burst_d = '0;
        layer_d = (layer_q == LAST_LAYER) ? '0 : layer_q + LAYER_W'(1);
      end else begin
        burst_d = burst_q + BURST_W'(1);
      end
    end
    if (start_i || adv_i) begin
      araddr_d = ADDR_WIDTH'(fb_burst_addr(64'(FB_BASE), 64'(FRAME_BYTES), 64'(LINE_BYTES),
                                           64'(BURST_BYTES), 64'(NUM_LAYERS), sel_i,
                                           64'(layer_d), 64'(line_i), 64'(burst_d)));
    end
  end

  // Counter and address registers; the address is held stable for the whole AR phase
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      layer_q  <= '0;
      burst_q  <= '0;
      araddr_q <= '0;
    end else begin
      layer_q  <= layer_d;
      burst_q  <= burst_d;
      araddr_q <= araddr_d;
    end
  end

  assign layer_o  = layer_q;
  assign burst_o  = burst_q;
  assign last_o   = (burst_q == LAST_BURST) && (layer_q == LAST_LAYER);
  assign araddr_o = araddr_q;

endmodule

// File: rtl/axi4_fb_line_fetcher.sv
// rtl/axi4_fb_line_fetcher.sv - AXI4 read master fetching one display line per layer into a ping-pong line buffer
module axi4_fb_line_fetcher
  import axi4_fb_pkg::*;
#(
  parameter int NUM_LAYERS      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 1,
  parameter int BURST_LEN       = 64,
  parameter int H_PIXELS        = 640,
  parameter int V_LINES         = 480,
  parameter int BYTES_PER_PIXEL = 4,
  parameter logic [ADDR_WIDTH-1:0] FB_BASE = ADDR_WIDTH'(32'h81000000),
  localparam int BEAT_BYTES      = DATA_WIDTH / 8,
  localparam int LINE_BYTES      = H_PIXELS * BYTES_PER_PIXEL,
  localparam int FRAME_BYTES     = LINE_BYTES * V_LINES,
  localparam int BEATS_PER_LINE  = LINE_BYTES / BEAT_BYTES,
  localparam int BURSTS_PER_LINE = BEATS_PER_LINE / BURST_LEN,
  localparam int LINE_W          = $clog2(V_LINES),
  localparam int LAYER_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int IDX_W           = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1
) (
  input  logic                  m00_axi_aclk,
  input  logic                  m00_axi_aresetn,
  input  logic                  line_req,
  input  logic [LINE_W-1:0]     line_idx,
  input  logic                  fb_sel,
  output logic [ID_WIDTH-1:0]   m00_axi_arid,
  output logic [ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [7:0]            m00_axi_arlen,
  output logic [2:0]            m00_axi_arsize,
  output logic [1:0]            m00_axi_arburst,
  output logic                  m00_axi_arlock,
  output logic [3:0]            m00_axi_arcache,
  output logic [2:0]            m00_axi_arprot,
  output logic [3:0]            m00_axi_arqos,
  output logic                  m00_axi_arvalid,
  input  logic                  m00_axi_arready,
  input  logic [DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]            m00_axi_rresp,
  input  logic                  m00_axi_rlast,
  input  logic                  m00_axi_rvalid,
  output logic                  m00_axi_rready,
  output logic                  lb_we,
  output logic [LAYER_W-1:0]    lb_layer,
  output logic [IDX_W:0]        lb_addr,
  output logic [DATA_WIDTH-1:0] lb_wdata,
  output logic                  busy,
  output logic                  line_done,
  output logic                  err_resp,
  output logic                  err_last,
  output logic                  overrun,
  input  logic                  clear_err
);

  localparam int BURST_W = (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
  localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  if ((BURST_LEN < 1) || (BURST_LEN > 256) || (LINE_BYTES % BEAT_BYTES != 0) ||
      (BEATS_PER_LINE % BURST_LEN != 0)) begin : g_bad_geometry
    $error("axi4_fb_line_fetcher: line must split into whole bursts of 1..256 beats");
  end

  fetch_state_e        state_q;
  logic [LINE_W-1:0]   line_q;
  logic                sel_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                arvalid_q, rready_q, busy_q, line_done_q;
  logic                err_resp_q, err_last_q, overrun_q;

  logic                start, beat_hs, last_beat, burst_end;
  logic                sel_next, ag_sel, ag_last;
  logic [LINE_W-1:0]   ag_line;
  logic [LAYER_W-1:0]  ag_layer;
  logic [BURST_W-1:0]  ag_burst;
  logic                resp_set, last_set, ovr_set;

  assign start     = (state_q == ST_IDLE) && line_req;
  assign beat_hs   = (state_q == ST_R) && rready_q && m00_axi_rvalid;
  assign last_beat = (beat_q == LAST_BEAT);
  assign burst_end = beat_hs && (m00_axi_rlast || last_beat);
  assign sel_next  = (line_idx == '0) ? fb_sel : sel_q;
  assign ag_line   = start ? line_idx : line_q;
  assign ag_sel    = start ? sel_next : sel_q;
  assign resp_set  = beat_hs && (m00_axi_rresp != AXI_RESP_OKAY);
  assign last_set  = burst_end && (m00_axi_rlast != last_beat);
  assign ovr_set   = line_req && (state_q != ST_IDLE);

  axi4_fb_addr_gen #(
    .NUM_LAYERS      (NUM_LAYERS),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .LINE_W          (LINE_W),
    .LAYER_W         (LAYER_W),
    .BURST_W         (BURST_W),
    .BURSTS_PER_LINE (BURSTS_PER_LINE),
    .LINE_BYTES      (LINE_BYTES),
    .FRAME_BYTES     (FRAME_BYTES),
    .BURST_BYTES     (BURST_LEN * BEAT_BYTES),
    .FB_BASE         (FB_BASE)
  ) u_addr_gen (
    .clk_i    (m00_axi_aclk),
    .rst_ni   (m00_axi_aresetn),
    .start_i  (start),
    .adv_i    (burst_end),
    .sel_i    (ag_sel),
    .line_i   (ag_line),
    .layer_o  (ag_layer),
    .burst_o  (ag_burst),
    .last_o   (ag_last),
    .araddr_o (m00_axi_araddr)
  );

  // Fetch sequencer: one outstanding burst at a time, sticky error flags with clear priority
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      sel_q       <= 1'b0;
      beat_q      <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      err_resp_q  <= 1'b0;
      err_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      if (clear_err) begin
        err_resp_q <= 1'b0;
        err_last_q <= 1'b0;
        overrun_q  <= 1'b0;
      end else begin
        if (resp_set) err_resp_q <= 1'b1;
        if (last_set) err_last_q <= 1'b1;
        if (ovr_set)  overrun_q  <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (line_req) begin
            line_q    <= line_idx;
            sel_q     <= sel_next;
            busy_q    <= 1'b1;
            arvalid_q <= 1'b1;
            state_q   <= ST_AR;
          end
        end
        ST_AR: begin
          if (m00_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (beat_hs) begin
            if (burst_end) begin
              rready_q <= 1'b0;
              beat_q   <= '0;
              if (ag_last) begin
                busy_q      <= 1'b0;
                line_done_q <= 1'b1;
                state_q     <= ST_DONE;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= ST_AR;
              end
            end else begin
              beat_q <= beat_q + BEAT_W'(1);
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m00_axi_arid    = '0;
  assign m00_axi_arlen   = 8'(BURST_LEN - 1);
  assign m00_axi_arsize  = 3'($clog2(BEAT_BYTES));
  assign m00_axi_arburst = AXI_BURST_INCR;
  assign m00_axi_arlock  = 1'b0;
  assign m00_axi_arcache = AXI_ARCACHE;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arqos   = 4'b0000;
  assign m00_axi_arvalid = arvalid_q;
  assign m00_axi_rready  = rready_q;

  assign lb_we    = beat_hs;
  assign lb_layer = ag_layer;
  assign lb_addr  = {line_q[0], IDX_W'(ag_burst) * IDX_W'(BURST_LEN) + IDX_W'(beat_q)};
  assign lb_wdata = m00_axi_rdata;

  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign err_resp  = err_resp_q;
  assign err_last  = err_last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_axi4_fb_line_fetcher.sv
// tb/tb_axi4_fb_line_fetcher.sv - self-checking bench for axi4_fb_line_fetcher
module tb_axi4_fb_line_fetcher;

  localparam int NL     = 2;
  localparam int BL     = 64;
  localparam int BPL    = 5;
  localparam int NAR    = NL * BPL;
  localparam int LINE_B = 2560;
  localparam int FRAME_B = 1228800;
  localparam longint unsigned BASE = 64'h81000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_req = 1'b0;
  logic [8:0]  line_idx = '0;
  logic        fb_sel = 1'b0;
  logic        clear_err = 1'b0;
  logic [0:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        lb_we;
  logic [0:0]  lb_layer;
  logic [9:0]  lb_addr;
  logic [63:0] lb_wdata;
  logic        busy, line_done, err_resp, err_last, overrun;

  always #5 clk = ~clk;

  axi4_fb_line_fetcher dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .line_req(line_req), .line_idx(line_idx), .fb_sel(fb_sel),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst), .m00_axi_arlock(arlock),
    .m00_axi_arcache(arcache), .m00_axi_arprot(arprot), .m00_axi_arqos(arqos),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .lb_we(lb_we), .lb_layer(lb_layer), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .busy(busy), .line_done(line_done), .err_resp(err_resp), .err_last(err_last),
    .overrun(overrun), .clear_err(clear_err)
  );

  typedef struct packed {
    logic [7:0]  layer;
    logic [15:0] addr;
  } wr_t;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_ar[$];
  wr_t         exp_wr[$];
  logic [31:0] dut_ar_log[$];
  int          wr_cnt = 0, bank1_cnt = 0, done_cnt = 0;
  logic [15:0] first_wr = '0, last_wr = '0;
  logic        sel_m = 1'b0;
  int          ar_delay = 0;
  bit          r_half = 1'b0;
  int          inj_resp_burst = -1, inj_resp_beat = 0;
  int          inj_last_burst = -1, inj_last_beat = 0;
  int          ar_total = 0, ar_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ar_at(input int i);
    if (i < dut_ar_log.size()) return dut_ar_log[i];
    return 'x;
  endfunction

  // Reference model: what one line fetch must issue and write, straight from the address rules
  task automatic build_model(input int line, input bit sel);
    longint unsigned a;
    int g, n;
    wr_t e;
    if (line == 0) sel_m = sel;
    for (int l = 0; l < NL; l++) begin
      for (int b = 0; b < BPL; b++) begin
        g = l * BPL + b;
        a = BASE + (sel_m ? longint'(NL) * FRAME_B : 0) + longint'(l) * FRAME_B
            + longint'(line) * LINE_B + longint'(b) * BL * 8;
        exp_ar.push_back(a[31:0]);
        n = (g == inj_last_burst) ? inj_last_beat + 1 : BL;
        for (int k = 0; k < n; k++) begin
          e.layer = 8'(l);
          e.addr  = 16'((line % 2) * 512 + b * BL + k);
          exp_wr.push_back(e);
        end
      end
    end
  endtask

  // AXI slave: configurable AR wait, optional 50% rvalid, error/early-rlast injection
  logic hs_ar, hs_r, arv;
  bit   r_active = 1'b0;
  int   r_beat = 0, r_burst = 0, ar_cnt = 0;
  always begin
    @(negedge clk);
    hs_ar = arvalid && arready;
    hs_r  = rvalid && rready;
    arv   = arvalid;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      r_active = 1'b0;
      ar_cnt   = 0;
      arready  = (ar_delay == 0);
      rvalid   = 1'b0;
      rlast    = 1'b0;
      rresp    = 2'b00;
    end else begin
      if (hs_ar) begin
        r_active = 1'b1;
        r_beat   = 0;
        r_burst  = ar_total - ar_base;
        ar_total++;
        ar_cnt   = 0;
        arready  = (ar_delay == 0);
      end else if (ar_delay != 0 && arv && !arready) begin
        ar_cnt++;
        if (ar_cnt >= ar_delay) arready = 1'b1;
      end else if (ar_delay == 0) begin
        arready = 1'b1;
      end
      if (hs_r) begin
        if (rlast) r_active = 1'b0;
        else r_beat++;
      end
      if (r_active) begin
        rvalid = r_half ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata  = {$urandom, $urandom};
        rlast  = (r_beat == BL - 1) || (r_burst == inj_last_burst && r_beat == inj_last_beat);
        rresp  = (r_burst == inj_resp_burst && r_beat == inj_resp_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  // Per-cycle compare of AR requests, AR stability and line-buffer writes against the model
  logic        prev_arv = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      prev_arv = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (prev_arv && !prev_hs) begin
        chk("arvalid_held", 64'(arvalid), 64'd1);
        chk("araddr_stable", 64'(araddr), 64'(prev_addr));
      end
      if (arvalid && arready) begin
        dut_ar_log.push_back(araddr);
        chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
        if (exp_ar.size() != 0) chk("araddr", 64'(araddr), 64'(exp_ar.pop_front()));
      end
      if (lb_we) begin
        wr_cnt++;
        if (wr_cnt == 1) first_wr = 16'(lb_addr);
        last_wr = 16'(lb_addr);
        if (lb_addr[9]) bank1_cnt++;
        chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("lb_addr", 64'(lb_addr), 64'(e.addr));
          chk("lb_layer", 64'(lb_layer), 64'(e.layer));
          chk("lb_wdata", lb_wdata, rdata);
        end
      end
      if (line_done) done_cnt++;
      prev_arv  = arvalid;
      prev_hs   = arvalid && arready;
      prev_addr = araddr;
    end
  end

  task automatic pulse_req(input int line, input bit sel);
    @(posedge clk); #1;
    line_req = 1'b1;
    line_idx = 9'(line);
    fb_sel   = sel;
    @(posedge clk); #1;
    line_req = 1'b0;
  endtask

  task automatic run_line(input int line, input bit sel, input int budget, input bit ovr);
    int c, d0;
    dut_ar_log.delete();
    wr_cnt = 0;
    bank1_cnt = 0;
    ar_base = ar_total;
    d0 = done_cnt;
    build_model(line, sel);
    pulse_req(line, sel);
    if (ovr) begin
      repeat (30) @(posedge clk);
      #1;
      chk("busy_mid_fetch", 64'(busy), 64'd1);
      pulse_req(9, 1'b0);
    end
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("line_done_count", 64'(done_cnt - d0), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("ar_left", 64'(exp_ar.size()), 64'd0);
    chk("wr_left", 64'(exp_wr.size()), 64'd0);
    chk("ar_count", 64'(dut_ar_log.size()), 64'(NAR));
    exp_ar.delete();
    exp_wr.delete();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_line_done", 64'(line_done), 64'd0);
    chk("rst_lb_we", 64'(lb_we), 64'd0);
    chk("rst_err_flags", 64'({err_resp, err_last, overrun}), 64'd0);
    chk("arlen", 64'(arlen), 64'd63);
    chk("arsize", 64'(arsize), 64'd3);
    chk("arburst", 64'(arburst), 64'd1);
    chk("arcache", 64'(arcache), 64'd3);
    chk("ar_misc", 64'({arid, arlock, arprot, arqos}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // line 0, primary buffers, zero-wait slave
    run_line(0, 1'b0, 3000, 1'b0);
    chk("t1_ar0", 64'(ar_at(0)), 64'h81000000);
    chk("t1_ar1", 64'(ar_at(1)), 64'h81000200);
    chk("t1_ar4", 64'(ar_at(4)), 64'h81000800);
    chk("t1_ar5", 64'(ar_at(5)), 64'h8112C000);
    chk("t1_ar9", 64'(ar_at(9)), 64'h8112C800);
    chk("t1_writes", 64'(wr_cnt), 64'd640);
    chk("t1_bank1_writes", 64'(bank1_cnt), 64'd0);
    chk("t1_err_flags", 64'({err_resp, err_last, overrun}), 64'd0);

    // alternate buffer latched at line 0, then line 5 with fb_sel low
    run_line(0, 1'b1, 3000, 1'b0);
    chk("t2_ar0_line0_alt", 64'(ar_at(0)), 64'h81258000);
    run_line(5, 1'b0, 3000, 1'b0);
    chk("t2_ar0", 64'(ar_at(0)), 64'h8125B200);
    chk("t2_ar5", 64'(ar_at(5)), 64'h81387200);
    chk("t2_first_wr", 64'(first_wr), 64'h200);

    // slow AR acceptance and bursty read data
    ar_delay = 7;
    r_half = 1'b1;
    run_line(7, 1'b0, 6000, 1'b0);
    chk("t3_writes", 64'(wr_cnt), 64'd640);
    chk("t3_first_wr", 64'(first_wr), 64'h200);
    chk("t3_last_wr", 64'(last_wr), 64'h33F);
    ar_delay = 0;
    r_half = 1'b0;

    // bad response and early rlast
    inj_resp_burst = 3;
    inj_resp_beat  = 10;
    inj_last_burst = 4;
    inj_last_beat  = 40;
    run_line(2, 1'b0, 3000, 1'b0);
    chk("t4_writes", 64'(wr_cnt), 64'd617);
    chk("t4_err_resp", 64'(err_resp), 64'd1);
    chk("t4_err_last", 64'(err_last), 64'd1);
    chk("t4_overrun", 64'(overrun), 64'd0);
    inj_resp_burst = -1;
    inj_last_burst = -1;
    pulse_clear();
    chk("t4_cleared", 64'({err_resp, err_last}), 64'd0);

    // request while busy
    run_line(3, 1'b0, 3000, 1'b1);
    chk("t5_overrun", 64'(overrun), 64'd1);
    chk("t5_other_flags", 64'({err_resp, err_last}), 64'd0);
    pulse_clear();
    chk("t5_cleared", 64'(overrun), 64'd0);

    // reset mid-burst, then a clean line 0
    dut_ar_log.delete();
    wr_cnt = 0;
    ar_base = ar_total;
    build_model(0, 1'b0);
    pulse_req(0, 1'b0);
    c = 0;
    while (wr_cnt < 20 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("t6_reached_burst", 64'(wr_cnt >= 20), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_arvalid", 64'(arvalid), 64'd0);
    chk("t6_rready", 64'(rready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_lb_we", 64'(lb_we), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_ar.delete();
    exp_wr.delete();
    rst_n = 1'b1;
    run_line(0, 1'b0, 3000, 1'b0);
    chk("t6_ar0", 64'(ar_at(0)), 64'h81000000);
    chk("t6_ar5", 64'(ar_at(5)), 64'h8112C000);
    chk("t6_writes", 64'(wr_cnt), 64'd640);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi4_fb_line_fetcher.md
Name: axi4_fb_line_fetcher

Overview:
AXI4 read master that fetches one display line from each of NUM_LAYERS framebuffer layers into a ping-pong line buffer on a line request from the video timing side. It is the parametrised successor of the fixed two-layer, 640-pixel FB reader. New in this generation:
- configurable layer count, geometry and burst length
- primary/alternate buffer select latched per frame
- line-parity bank addressing
- sticky protocol error reporting

It sits between the video timing/HDMI pixel path and the DDR interconnect.

Parameters:
NUM_LAYERS, 2, framebuffer layers fetched per line, in order 0..N-1
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width; a multiple of 8*BYTES_PER_PIXEL
ID_WIDTH, 1, AXI ID width; arid tied to 0
BURST_LEN, 64, beats per burst; 1..256
H_PIXELS, 640, pixels per line
V_LINES, 480, lines per frame
BYTES_PER_PIXEL, 4, bytes per pixel
FB_BASE, 32'h81000000, base address of layer 0 primary buffer
Derived localparams:
- LINE_BYTES = H_PIXELS*BYTES_PER_PIXEL
- FRAME_BYTES = LINE_BYTES*V_LINES
- BEATS_PER_LINE = LINE_BYTES/(DATA_WIDTH/8)
- BURSTS_PER_LINE = BEATS_PER_LINE/BURST_LEN (must divide exactly; elaboration $error otherwise)

Ports:
m00_axi_aclk  in  1  clock
m00_axi_aresetn  in  1  asynchronous active-low reset
line_req  in  1  one-cycle pulse: fetch line line_idx
line_idx  in  $clog2(V_LINES)  line to fetch
fb_sel  in  1  0 = primary buffers, 1 = alternate buffers; sampled at line 0
m00_axi_arid  out  ID_WIDTH  constant 0
m00_axi_araddr  out  ADDR_WIDTH  burst byte address
m00_axi_arlen  out  8  BURST_LEN-1
m00_axi_arsize  out  3  $clog2(DATA_WIDTH/8)
m00_axi_arburst  out  2  2'b01 INCR
m00_axi_arlock/arcache/arprot/arqos  out  1/4/3/4  0 / 4'b0011 / 0 / 0
m00_axi_arvalid  out  1  address valid
m00_axi_arready  in  1  address ready
m00_axi_rdata  in  DATA_WIDTH  read data
m00_axi_rresp  in  2  read response
m00_axi_rlast  in  1  last beat
m00_axi_rvalid  in  1  data valid
m00_axi_rready  out  1  data ready
lb_we  out  1  line buffer write strobe
lb_layer  out  max(1,$clog2(NUM_LAYERS))  destination layer
lb_addr  out  1+$clog2(BEATS_PER_LINE)  {bank = line_idx[0], beat index}
lb_wdata  out  DATA_WIDTH  rdata, passed through unregistered
busy  out  1  fetch in progress
line_done  out  1  one-cycle pulse after last beat of last layer
err_resp  out  1  sticky: any rresp != 0
err_last  out  1  sticky: rlast mismatch with beat count
overrun  out  1  sticky: line_req arrived while busy
clear_err  in  1  synchronous clear of all sticky flags

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except constant AR fields. Latched buffer select = 0. An in-flight burst is abandoned; arvalid and rready drop immediately.
- States: IDLE -> AR -> R -> (AR | DONE) -> IDLE.
- IDLE:
  - line_req latches line_idx, sets layer=0, burst=0 and busy=1, then enters AR.
  - If line_idx==0, fb_sel is latched in the same cycle.
  - line_req while busy is ignored and sets overrun.
- AR:
  - arvalid=1 on the cycle after acceptance. araddr and arvalid are held stable until arready.
  - araddr = FB_BASE + (sel ? NUM_LAYERS*FRAME_BYTES : 0) + layer*FRAME_BYTES + line*LINE_BYTES + burst*BURST_LEN*(DATA_WIDTH/8), computed at ADDR_WIDTH.
  - On handshake: arvalid falls next cycle; enter R.
  - Only one outstanding burst at a time.
- R:
  - rready=1 throughout.
  - Each rvalid beat produces lb_we=1, lb_addr={bank, burst*BURST_LEN+beat}, lb_layer=layer in the same cycle (combinational from rvalid), then beat++.
  - The burst ends on rlast or on beat BURST_LEN-1, whichever comes first.
  - If those two do not coincide, set err_last.
  - On a missing rlast, rready is held at 0 after beat BURST_LEN-1. There is no further wait.
  - rresp != 0 sets err_resp; the data is still written.
- Burst end:
  - burst++. On wrap to 0, layer++.
  - If layer wraps past NUM_LAYERS-1, go to DONE; otherwise return to AR.
- DONE: line_done=1 for one cycle, busy=0, return to IDLE. A new line_req is accepted on the following cycle.
- clear_err has priority over a simultaneous set.

Decomposition:
- Package axi4_fb_pkg: state enum, AXI constants (INCR, RESP_OKAY, ARCACHE value), and a function computing line/burst address.
- One sub-module, axi4_fb_addr_gen: registered layer/burst counters and araddr computation.

Test Plan:
- Defaults, line_req line 0, fb_sel=0, zero-wait slave → 10 ARs at 0x81000000, +0x200 ... 0x81000800, then 0x8112C000 ... 0x8112C800. Expect 640 lb_we with bank 0, line_done once, no error flags.
- Line 5, fb_sel latched 1 at line 0, fb_sel=0 at request → first araddr 0x8125B200. Layer-1 first araddr 0x81387200. lb_addr bank bit = 1.
- arready delayed 7 cycles, rvalid toggling 50% → araddr/arvalid stable through the wait. Exactly 320 writes per layer with contiguous lb_addr 0x200..0x33F.
- rresp=2'b10 on beat 10 of burst 3; rlast early at beat 40 of burst 4 → err_resp=1 and err_last=1. Fetch completes with line_done. clear_err returns both flags to 0.
- line_req while busy → overrun=1, no extra AR issued.
- Reset asserted mid-burst → arvalid=rready=busy=0 immediately. A subsequent line 0 fetch is correct.
